// File: rtl/shift_engine_pkg.sv
`default_nettype none
// ============================================================================
// Module   : shift_engine_pkg
// Purpose  : Op-code constants and FSM state encoding shared by the shift
//            engine, its step shifter and its handshake interface.
// Revision : 1.0  initial release
// ============================================================================
package shift_engine_pkg;

  localparam logic [2:0] OP_NOP  = 3'b000;
  localparam logic [2:0] OP_LOAD = 3'b001;
  localparam logic [2:0] OP_LSL  = 3'b010;
  localparam logic [2:0] OP_LSR  = 3'b011;
  localparam logic [2:0] OP_ASR  = 3'b100;
  localparam logic [2:0] OP_ROL  = 3'b101;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_t;

  // True for the four op codes that move bits (LSL, LSR, ASR, ROL).
  function automatic logic is_shift_op(input logic [2:0] op);
    return (op == OP_LSL) || (op == OP_LSR) || (op == OP_ASR) || (op == OP_ROL);
  endfunction

endpackage : shift_engine_pkg
`default_nettype wire

// File: rtl/shift_engine_if.sv
`default_nettype none
// ============================================================================
// Module   : shift_engine_if
// Purpose  : Request/response bundle of the shift engine. The master issues
//            requests; the slave (the engine) answers with ready/data/status.
// Revision : 1.0  initial release
// ============================================================================
interface shift_engine_if #(
  parameter int WIDTH   = 8,
  parameter int SHAMT_W = 3
);

  logic               op_valid;
  logic               op_ready;
  logic [2:0]         op_code;
  logic [SHAMT_W-1:0] shamt;
  logic [WIDTH-1:0]   d_in;
  logic [WIDTH-1:0]   d_out;
  logic               busy;
  logic               done;

  modport master (
    output op_valid, op_code, shamt, d_in,
    input  op_ready, d_out, busy, done
  );

  modport slave (
    input  op_valid, op_code, shamt, d_in,
    output op_ready, d_out, busy, done
  );

endinterface : shift_engine_if
`default_nettype wire

// File: rtl/shift_engine_step.sv
`default_nettype none
// ============================================================================
// Module   : shift_step
// Purpose  : Combinational single-step shifter. Every output bit is one
//            2**STEP_W:1 mux over the bits it could receive for each step
//            amount, with the candidate set chosen by the op code.
// Revision : 1.0  initial release
// ============================================================================
module shift_step
  import shift_engine_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int STEP_W = 2
) (
  input  logic [WIDTH-1:0]  d_i,
  input  logic [2:0]        op_i,
  input  logic [STEP_W-1:0] amt_i,
  output logic [WIDTH-1:0]  d_o
);

  localparam int NAMT = 2 ** STEP_W;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    logic [NAMT-1:0] w_cand;

    for (genvar k = 0; k < NAMT; k++) begin : g_amt
      localparam int SRC_L   = i - k;
      localparam int SRC_R   = i + k;
      localparam int SRC_ROT = ((i - k) % WIDTH + WIDTH) % WIDTH;

      logic w_lsl;
      logic w_lsr;
      logic w_asr;

      if (SRC_L >= 0) begin : g_lsl_src
        assign w_lsl = d_i[SRC_L];
      end else begin : g_lsl_zero
        assign w_lsl = 1'b0;
      end

      if (SRC_R < WIDTH) begin : g_lsr_src
        assign w_lsr = d_i[SRC_R];
        assign w_asr = d_i[SRC_R];
      end else begin : g_lsr_fill
        assign w_lsr = 1'b0;
        assign w_asr = d_i[WIDTH-1];
      end

      // Non-shift op codes pass the bit through unchanged.
      assign w_cand[k] = (op_i == OP_LSL) ? w_lsl :
                         (op_i == OP_LSR) ? w_lsr :
                         (op_i == OP_ASR) ? w_asr :
                         (op_i == OP_ROL) ? d_i[SRC_ROT] :
                                            d_i[i];
    end

    assign d_o[i] = w_cand[amt_i];
  end

endmodule : shift_step
`default_nettype wire

// File: rtl/shift_engine.sv
`default_nettype none
// ============================================================================
// Module   : shift_engine
// Purpose  : Loadable WIDTH-bit shift register with accept/done handshake.
//            A shift of shamt positions is split into steps of at most
//            STEP_MAX = 2**STEP_W-1 positions, one step per clock.
//            SHAMT_W must be >= STEP_W.
// Revision : 1.0  initial release
// ============================================================================
module shift_engine
  import shift_engine_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int SHAMT_W = 3,
  parameter int STEP_W  = 2
) (
  input  logic           clk,
  input  logic           reset,
  shift_engine_if.slave  bus
);

  localparam int                 STEP_MAX   = 2 ** STEP_W - 1;
  localparam logic [SHAMT_W-1:0] STEP_MAX_S = SHAMT_W'(STEP_MAX);

  state_t             state_q;
  logic [SHAMT_W-1:0] remaining_q;
  logic [2:0]         op_q;
  logic [WIDTH-1:0]   d_out_q;
  logic               done_q;

  logic [STEP_W-1:0]  step_d;
  logic [SHAMT_W-1:0] remaining_d;
  logic [WIDTH-1:0]   shifted_d;

  // Size of the current step and the count left after it.
  always_comb begin
    step_d      = STEP_MAX[STEP_W-1:0];
    if (remaining_q < STEP_MAX_S) begin
      step_d = remaining_q[STEP_W-1:0];
    end
    remaining_d = remaining_q - SHAMT_W'(step_d);
  end

  shift_step #(
    .WIDTH  (WIDTH),
    .STEP_W (STEP_W)
  ) u_shift_step (
    .d_i   (d_out_q),
    .op_i  (op_q),
    .amt_i (step_d),
    .d_o   (shifted_d)
  );

  // Control FSM: accepts requests in IDLE, iterates shift steps in SHIFT.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      remaining_q <= '0;
      op_q        <= OP_NOP;
      d_out_q     <= '0;
      done_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (bus.op_valid) begin
            if (bus.op_code == OP_LOAD) begin
              d_out_q <= bus.d_in;
              done_q  <= 1'b1;
            end else if (is_shift_op(bus.op_code) && (bus.shamt != '0)) begin
              remaining_q <= bus.shamt;
              op_q        <= bus.op_code;
              state_q     <= ST_SHIFT;
            end else begin
              // NOP, reserved codes and zero-length shifts complete at once.
              done_q <= 1'b1;
            end
          end
        end
        ST_SHIFT: begin
          d_out_q     <= shifted_d;
          remaining_q <= remaining_d;
          if (remaining_d == '0) begin
            state_q <= ST_IDLE;
            done_q  <= 1'b1;
          end
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.op_ready = (state_q == ST_IDLE);
  assign bus.busy     = (state_q == ST_SHIFT);
  assign bus.d_out    = d_out_q;
  assign bus.done     = done_q;

endmodule : shift_engine
`default_nettype wire

// File: tb/tb_shift_engine.sv
`default_nettype none
// ============================================================================
// Module   : tb_shift_engine
// Purpose  : Directed self-checking bench for shift_engine (8/3/2 config).
// Revision : 1.0  initial release
// ============================================================================
module tb_shift_engine;

  localparam logic [2:0] C_NOP  = 3'b000;
  localparam logic [2:0] C_LOAD = 3'b001;
  localparam logic [2:0] C_LSL  = 3'b010;
  localparam logic [2:0] C_LSR  = 3'b011;
  localparam logic [2:0] C_ASR  = 3'b100;
  localparam logic [2:0] C_ROL  = 3'b101;
  localparam logic [2:0] C_RSV  = 3'b111;

  logic clk = 1'b0;
  logic reset;
  int   n_cmp = 0;
  int   n_err = 0;
  int   lat;

  shift_engine_if #(.WIDTH(8), .SHAMT_W(3)) bus ();

  shift_engine #(.WIDTH(8), .SHAMT_W(3), .STEP_W(2)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Advance one clock; sample and drive 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [2:0] code, input logic [2:0] sh, input logic [7:0] din);
    bus.op_valid = 1'b1;
    bus.op_code  = code;
    bus.shamt    = sh;
    bus.d_in     = din;
  endtask

  // Issue one op, then count edges after the accept edge until done.
  task automatic run_op(input logic [2:0] code, input logic [2:0] sh,
                        input logic [7:0] din, output int edges);
    drive(code, sh, din);
    tick();
    bus.op_valid = 1'b0;
    edges = 0;
    while (!bus.done && edges < 20) begin
      tick();
      edges++;
    end
    if (edges >= 20) check("done_timeout", 32'(edges), 32'd0);
  endtask

  initial begin
    reset        = 1'b1;
    bus.op_valid = 1'b0;
    bus.op_code  = C_NOP;
    bus.shamt    = '0;
    bus.d_in     = '0;
    tick();
    tick();
    check("rst_dout",  32'(bus.d_out), 32'h00);
    check("rst_ready", 32'(bus.op_ready), 32'd1);
    check("rst_busy",  32'(bus.busy), 32'd0);
    check("rst_done",  32'(bus.done), 32'd0);
    reset = 1'b0;
    tick();

    // 1. LOAD B5
    drive(C_LOAD, 3'd0, 8'hB5);
    tick();
    bus.op_valid = 1'b0;
    check("load_dout",  32'(bus.d_out), 32'hB5);
    check("load_done",  32'(bus.done), 32'd1);
    check("load_ready", 32'(bus.op_ready), 32'd1);
    check("load_busy",  32'(bus.busy), 32'd0);
    tick();
    check("load_done_clr", 32'(bus.done), 32'd0);

    // 2. LSL 5 from B5: A8 then A0
    drive(C_LSL, 3'd5, 8'h00);
    tick();
    bus.op_valid = 1'b0;
    check("lsl_acc_dout",  32'(bus.d_out), 32'hB5);
    check("lsl_acc_busy",  32'(bus.busy), 32'd1);
    check("lsl_acc_ready", 32'(bus.op_ready), 32'd0);
    tick();
    check("lsl_s1_dout", 32'(bus.d_out), 32'hA8);
    check("lsl_s1_busy", 32'(bus.busy), 32'd1);
    check("lsl_s1_done", 32'(bus.done), 32'd0);
    tick();
    check("lsl_s2_dout", 32'(bus.d_out), 32'hA0);
    check("lsl_s2_busy", 32'(bus.busy), 32'd0);
    check("lsl_s2_done", 32'(bus.done), 32'd1);
    tick();
    check("lsl_done_clr", 32'(bus.done), 32'd0);

    // 3. ASR 7 from 80: F0, FE, FF
    run_op(C_LOAD, 3'd0, 8'h80, lat);
    tick();
    drive(C_ASR, 3'd7, 8'h00);
    tick();
    bus.op_valid = 1'b0;
    tick();
    check("asr_s1", 32'(bus.d_out), 32'hF0);
    tick();
    check("asr_s2", 32'(bus.d_out), 32'hFE);
    check("asr_s2_done", 32'(bus.done), 32'd0);
    tick();
    check("asr_s3", 32'(bus.d_out), 32'hFF);
    check("asr_done", 32'(bus.done), 32'd1);
    tick();

    // LSR 7 from 80
    run_op(C_LOAD, 3'd0, 8'h80, lat);
    tick();
    run_op(C_LSR, 3'd7, 8'h00, lat);
    check("lsr_dout", 32'(bus.d_out), 32'h01);
    check("lsr_lat",  32'(lat), 32'd3);
    tick();

    // 4. ROL 4 from B5 with a LOAD held during busy
    run_op(C_LOAD, 3'd0, 8'hB5, lat);
    check("load_lat", 32'(lat), 32'd0);
    tick();
    drive(C_ROL, 3'd4, 8'h00);
    tick();
    drive(C_LOAD, 3'd0, 8'h00);
    tick();
    check("rol_s1", 32'(bus.d_out), 32'hAD);
    tick();
    bus.op_valid = 1'b0;
    check("rol_dout", 32'(bus.d_out), 32'h5B);
    check("rol_done", 32'(bus.done), 32'd1);
    tick();
    check("rol_hold", 32'(bus.d_out), 32'h5B);
    check("rol_done_clr", 32'(bus.done), 32'd0);

    // 5. zero-length / NOP / reserved, back-to-back in done cycles
    drive(C_LSL, 3'd0, 8'h00);
    tick();
    check("sh0_done", 32'(bus.done), 32'd1);
    check("sh0_busy", 32'(bus.busy), 32'd0);
    check("sh0_dout", 32'(bus.d_out), 32'h5B);
    drive(C_NOP, 3'd3, 8'hFF);
    tick();
    check("nop_done", 32'(bus.done), 32'd1);
    check("nop_dout", 32'(bus.d_out), 32'h5B);
    drive(C_RSV, 3'd2, 8'hFF);
    tick();
    bus.op_valid = 1'b0;
    check("rsv_done", 32'(bus.done), 32'd1);
    check("rsv_busy", 32'(bus.busy), 32'd0);
    check("rsv_dout", 32'(bus.d_out), 32'h5B);
    tick();
    check("rsv_done_clr", 32'(bus.done), 32'd0);

    // Back-to-back: shift accepted in the done cycle of a LOAD
    run_op(C_LOAD, 3'd0, 8'h81, lat);
    run_op(C_ROL, 3'd1, 8'h00, lat);
    check("b2b_rol_dout", 32'(bus.d_out), 32'h03);
    check("b2b_rol_lat",  32'(lat), 32'd1);
    tick();

    // 6. reset on the 2nd cycle of LSL 7 from 03
    drive(C_LSL, 3'd7, 8'h00);
    tick();
    bus.op_valid = 1'b0;
    tick();
    check("abort_s1", 32'(bus.d_out), 32'h18);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("abort_dout",  32'(bus.d_out), 32'h00);
    check("abort_ready", 32'(bus.op_ready), 32'd1);
    check("abort_busy",  32'(bus.busy), 32'd0);
    check("abort_done",  32'(bus.done), 32'd0);
    for (int i = 0; i < 4; i++) begin
      tick();
      check("abort_nodone", 32'(bus.done), 32'd0);
    end
    check("abort_dout_hold", 32'(bus.d_out), 32'h00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule : tb_shift_engine
`default_nettype wire
